pipe_stage_skid: RTL

- Generic, parametrised inter-stage pipeline register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the per-stage hand-written register blocks. Each stage packs its fields into one payload bus.
- Provides a valid/allow-in handshake, flush with NOP injection, and an optional 2-entry skid buffer. The skid buffer registers the upstream allow-in and so breaks the combinational backpressure chain.
- Carries saturating stall and bubble counters for performance analysis.

---
 rtl/pipe_stage_skid.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
//------------------------------------------------------------------------------
// Module      : pipe_stage_skid
// Description : Parametrised inter-stage pipeline register with valid/allow-in
//               handshake, flush-to-NOP, optional 2-entry skid buffer and
//               saturating stall/bubble performance counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid #(
  parameter int                 DATA_W    = 256,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter bit                 SKID_EN   = 1'b1,
  parameter int                 CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              allow_in_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              next_allow_in_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  bubble_q;

  assign out_valid_o  = (state_q != EMPTY);
  assign out_data_o   = main_q;
  assign occupancy_o  = state_q;
  assign w_push       = in_valid_i & allow_in_o;
  assign w_pop        = out_valid_o & next_allow_in_i;
  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_push) begin
            main_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            main_d = in_data_i;
          end else if (w_push) begin
            state_d = FULL;
          end else if (w_pop) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          main_d  = NOP_VALUE;
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      // Allow-in comes from registered state only, cutting the backpressure path.
      assign allow_in_o = (state_q != FULL);

      always_ff @(posedge clk_i) begin
        if (rst || flush_i) begin
          skid_q <= NOP_VALUE;
        end else if (state_q == ONE && w_push && !w_pop) begin
          skid_q <= in_data_i;
        end else if (state_q == FULL && w_pop) begin
          skid_q <= NOP_VALUE;
        end
      end
    end else begin : g_noskid
      assign allow_in_o = (state_q == EMPTY) | next_allow_in_i;
      assign skid_q     = NOP_VALUE;
    end
  endgenerate

  // Counters see pre-edge handshake values and keep counting through a flush.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid_o && !next_allow_in_i && stall_q != c_cnt_max) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (!out_valid_o && next_allow_in_i && bubble_q != c_cnt_max) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
